// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default parameters for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MEM_LAT     = 1;
    localparam int DEF_D_BURST_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and load/store, with a data-streak limit so fetch cannot starve.
module mem_port_arbiter_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int D_BURST_MAX = DEF_D_BURST_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic idle,
    input  logic fire,
    output logic win_d,
    output logic win_i
);

    localparam int SW = $clog2(D_BURST_MAX + 1);

    logic [SW-1:0] d_streak_q;
    logic          at_max;

    assign at_max = (d_streak_q == SW'(D_BURST_MAX));
    assign win_d  = idle & d_req & ~(i_req & at_max);
    assign win_i  = idle & i_req & ~win_d;

    // Streak only grows while fetch is actually waiting behind data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_streak_q <= '0;
        end else if (fire) begin
            if (win_d && i_req) begin
                d_streak_q <= at_max ? d_streak_q : d_streak_q + 1'b1;
            end else begin
                d_streak_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LAT     = DEF_MEM_LAT,
    parameter int D_BURST_MAX = DEF_D_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrate; a stale req from the last ack edge is ignored here
    // ACC   | memory strobed for MEM_LAT cycles, rdata sampled on the last
    // ACK   | one-cycle ack to the granted port
    localparam int          CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e              state_q;
    grant_e              grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_ack_q;
    logic                d_ack_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic                win_d;
    logic                win_i;
    logic                idle;

    assign idle = (state_q == ST_IDLE);

    mem_port_arbiter_prio #(
        .D_BURST_MAX(D_BURST_MAX)
    ) u_prio (
        .clk   (clk),
        .reset (reset),
        .i_req (i_req),
        .d_req (d_req),
        .idle  (idle),
        .fire  (win_d | win_i),
        .win_d (win_d),
        .win_i (win_i)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_I;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    if (win_d || win_i) begin
                        state_q     <= ST_ACC;
                        cnt_q       <= '0;
                        grant_q     <= win_d ? GNT_D : GNT_I;
                        addr_q      <= win_d ? d_addr : i_addr;
                        we_q        <= win_d & d_we;
                        mem_read_q  <= win_i | ~d_we;
                        mem_write_q <= win_d & d_we;
                        if (win_d) begin
                            wdata_q <= d_wdata;
                        end
                    end
                end
                ST_ACC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_ACK;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (grant_q == GNT_I) begin
                            i_rdata_q <= mem_rdata;
                            i_ack_q   <= 1'b1;
                        end else begin
                            d_ack_q <= 1'b1;
                            if (!we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = ~idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a single-cycle-latency instance for vectors and burst order, a 3-cycle one for latency/reset.
module tb_mem_port_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance
    logic        rst1, ireq1, iack1, dreq1, dwe1, dack1, mrd1, mwr1, busy1;
    logic [31:0] iaddr1, irdata1, daddr1, dwdata1, drdata1, maddr1, mwdata1, mrdata1;
    // MEM_LAT=3 instance
    logic        rst3, ireq3, iack3, dreq3, dwe3, dack3, mrd3, mwr3, busy3;
    logic [31:0] iaddr3, irdata3, daddr3, dwdata3, drdata3, maddr3, mwdata3, mrdata3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .D_BURST_MAX(4)) u1 (
        .clk(clk), .reset(rst1), .i_req(ireq1), .i_addr(iaddr1), .i_rdata(irdata1),
        .i_ack(iack1), .d_req(dreq1), .d_we(dwe1), .d_addr(daddr1), .d_wdata(dwdata1),
        .d_rdata(drdata1), .d_ack(dack1), .mem_addr(maddr1), .mem_wdata(mwdata1),
        .mem_read(mrd1), .mem_write(mwr1), .mem_rdata(mrdata1), .busy(busy1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .D_BURST_MAX(4)) u3 (
        .clk(clk), .reset(rst3), .i_req(ireq3), .i_addr(iaddr3), .i_rdata(irdata3),
        .i_ack(iack3), .d_req(dreq3), .d_we(dwe3), .d_addr(daddr3), .d_wdata(dwdata3),
        .d_rdata(drdata3), .d_ack(dack3), .mem_addr(maddr3), .mem_wdata(mwdata3),
        .mem_read(mrd3), .mem_write(mwr3), .mem_rdata(mrdata3), .busy(busy3)
    );

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] mrdata;
        logic        e_iack;
        logic        e_dack;
        logic        e_rd;
        logic        e_wr;
        logic        e_busy;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C220004,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0,        32'h0,        32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C220004,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0,        32'h8C220004, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'h8C220004, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h12345678,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C220004, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h12345678,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h8C220004, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'hDEADBEEF, 32'h8C220004, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h44, 32'hDEADBEEF, 32'hCAFEF00D,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h8C220004, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h44, 32'hDEADBEEF, 32'hCAFEF00D,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h8C220004, 32'hCAFEF00D};
        vecs[9] = '{1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h44, 32'hDEADBEEF, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'hDEADBEEF, 32'h8C220004, 32'hCAFEF00D};

        rst1 = 1'b0; ireq1 = 1'b0; iaddr1 = '0; dreq1 = 1'b0; dwe1 = 1'b0;
        daddr1 = '0; dwdata1 = '0; mrdata1 = '0;
        rst3 = 1'b0; ireq3 = 1'b1; iaddr3 = 32'h20; dreq3 = 1'b1; dwe3 = 1'b0;
        daddr3 = 32'h80; dwdata3 = '0; mrdata3 = '0;
        #1;

        // ---- table-driven vectors on the MEM_LAT=1 instance ----
        for (int i = 0; i < NV; i++) begin
            rst1 = vecs[i].rst;   ireq1 = vecs[i].ireq; iaddr1 = vecs[i].iaddr;
            dreq1 = vecs[i].dreq; dwe1 = vecs[i].dwe;   daddr1 = vecs[i].daddr;
            dwdata1 = vecs[i].dwdata; mrdata1 = vecs[i].mrdata;
            step();
            chk($sformatf("v%0d.i_ack", i),     {31'b0, iack1}, {31'b0, vecs[i].e_iack});
            chk($sformatf("v%0d.d_ack", i),     {31'b0, dack1}, {31'b0, vecs[i].e_dack});
            chk($sformatf("v%0d.mem_read", i),  {31'b0, mrd1},  {31'b0, vecs[i].e_rd});
            chk($sformatf("v%0d.mem_write", i), {31'b0, mwr1},  {31'b0, vecs[i].e_wr});
            chk($sformatf("v%0d.busy", i),      {31'b0, busy1}, {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d.mem_addr", i),  maddr1,  vecs[i].e_maddr);
            chk($sformatf("v%0d.mem_wdata", i), mwdata1, vecs[i].e_mwdata);
            chk($sformatf("v%0d.i_rdata", i),   irdata1, vecs[i].e_irdata);
            chk($sformatf("v%0d.d_rdata", i),   drdata1, vecs[i].e_drdata);
        end

        // ---- both requests held: grant order with burst limit ----
        begin
            int exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
            int got_g[10];
            int ng = 0;
            int both = 0;
            ireq1 = 1'b1; dreq1 = 1'b1; dwe1 = 1'b0;
            for (int c = 0; c < 60 && ng < 10; c++) begin
                step();
                if (iack1 && dack1) both++;
                if (dack1) begin
                    got_g[ng] = 1; ng++;
                end else if (iack1) begin
                    got_g[ng] = 0; ng++;
                end
            end
            ireq1 = 1'b0; dreq1 = 1'b0;
            chk("burst.grants_seen", ng, 10);
            chk("burst.dual_ack_cycles", both, 0);
            for (int k = 0; k < ng; k++) begin
                chk($sformatf("burst.grant%0d_is_d", k), got_g[k], exp_g[k]);
            end
        end

        // ---- MEM_LAT=3: reset state, then load latency ----
        chk("lat3.reset_busy", {31'b0, busy3}, 32'd0);
        chk("lat3.reset_mem_read", {31'b0, mrd3}, 32'd0);
        chk("lat3.reset_acks", {30'b0, iack3, dack3}, 32'd0);
        begin
            logic exp_rd[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            logic exp_ack[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            ireq3 = 1'b0; dreq3 = 1'b1; dwe3 = 1'b0; daddr3 = 32'h80; mrdata3 = 32'h0BADCAFE;
            rst3 = 1'b1;
            for (int s = 0; s < 5; s++) begin
                step();
                chk($sformatf("lat3.s%0d.mem_read", s), {31'b0, mrd3}, {31'b0, exp_rd[s]});
                chk($sformatf("lat3.s%0d.d_ack", s), {31'b0, dack3}, {31'b0, exp_ack[s]});
                if (s == 0) chk("lat3.mem_addr", maddr3, 32'h80);
                if (s == 3) begin
                    chk("lat3.d_rdata", drdata3, 32'h0BADCAFE);
                    dreq3 = 1'b0;
                end
            end
        end

        // ---- MEM_LAT=3: reset asserted mid-access ----
        begin
            int acks = 0;
            int wait_c = 0;
            logic got = 1'b0;
            dreq3 = 1'b1; dwe3 = 1'b0; daddr3 = 32'h84; mrdata3 = 32'h55AA33CC;
            step();
            step();
            chk("abort.pre_mem_read", {31'b0, mrd3}, 32'd1);
            rst3 = 1'b0;
            #1;
            chk("abort.mem_read_drop", {31'b0, mrd3}, 32'd0);
            chk("abort.busy_drop", {31'b0, busy3}, 32'd0);
            for (int c = 0; c < 3; c++) begin
                step();
                if (dack3) acks++;
            end
            chk("abort.no_ack", acks, 0);
            rst3 = 1'b1;
            #1;
            chk("abort.idle_after_release", {31'b0, busy3}, 32'd0);
            step();
            chk("abort.regrant_mem_read", {31'b0, mrd3}, 32'd1);
            chk("abort.regrant_addr", maddr3, 32'h84);
            while (!got && wait_c < 10) begin
                step();
                wait_c++;
                if (dack3) got = 1'b1;
            end
            chk("abort.regrant_ack_seen", {31'b0, got}, 32'd1);
            chk("abort.regrant_ack_cycle", wait_c, 3);
            chk("abort.regrant_d_rdata", drdata3, 32'h55AA33CC);
            dreq3 = 1'b0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
